// File: rtl/signed_display_scan.sv
// signed_display_scan: signed 8-bit value to sign + 3 BCD digits, multiplexed onto a 4-digit common-anode display
// Ports: clk, rst (sync, active-high); valor (signed value), cargar (load strobe, taken while idle);
// ocupado (conversion in progress); anodos (active-low one-hot digit enable, bit 3 = sign);
// segmentos (active-low gfedcba)
module signed_display_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] valor,
    input  logic       cargar,
    output logic       ocupado,
    output logic [3:0] anodos,
    output logic [6:0] segmentos
);
    localparam logic [1:0] IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2;
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] BLANK = 7'b1111111, MINUS = 7'b0111111;
    logic [1:0] state;
    logic [2:0] it;
    logic [7:0] mag;
    logic [11:0] bcd, adj;
    logic signo, disp_s;
    logic [3:0] disp_h, disp_t, disp_u;
    logic [RW-1:0] ref_cnt;
    logic [1:0] idx;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b1000000;
            4'd1: seg7 = 7'b1111001;
            4'd2: seg7 = 7'b0100100;
            4'd3: seg7 = 7'b0110000;
            4'd4: seg7 = 7'b0011001;
            4'd5: seg7 = 7'b0010010;
            4'd6: seg7 = 7'b0000010;
            4'd7: seg7 = 7'b1111000;
            4'd8: seg7 = 7'b0000000;
            4'd9: seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction
    always_comb begin
        adj[3:0]  = bcd[3:0]  >= 4'd5 ? bcd[3:0]  + 4'd3 : bcd[3:0];
        adj[7:4]  = bcd[7:4]  >= 4'd5 ? bcd[7:4]  + 4'd3 : bcd[7:4];
        adj[11:8] = bcd[11:8] >= 4'd5 ? bcd[11:8] + 4'd3 : bcd[11:8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            it     <= 3'd0;
            mag    <= 8'd0;
            bcd    <= 12'd0;
            signo  <= 1'b0;
            disp_s <= 1'b0;
            disp_h <= 4'd0;
            disp_t <= 4'd0;
            disp_u <= 4'd0;
        end else begin
            case (state)
                IDLE: if (cargar) begin
                    state <= CONV;
                    signo <= valor[7];
                    mag   <= valor[7] ? 8'(~valor + 8'd1) : valor;
                    bcd   <= 12'd0;
                    it    <= 3'd0;
                end
                CONV: begin
                    {bcd, mag} <= {adj, mag} << 1;
                    it         <= it + 3'd1;
                    state      <= it == 3'd7 ? COMMIT : CONV;
                end
                default: begin
                    {disp_h, disp_t, disp_u} <= bcd;
                    disp_s <= signo;
                    state  <= IDLE;
                end
            endcase
        end
    end
    // Scan timing is deliberately independent of the conversion FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt <= '0;
            idx     <= 2'd0;
        end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end
    assign ocupado = state != IDLE;
    assign anodos  = ~(4'b0001 << idx);
    // Leading-zero blanking: tens is blank only when hundreds is blank too.
    assign segmentos = idx == 2'd3 ? (disp_s ? MINUS : BLANK) :
                       idx == 2'd2 ? (disp_h == 4'd0 ? BLANK : seg7(disp_h)) :
                       idx == 2'd1 ? ((disp_h == 4'd0 && disp_t == 4'd0) ? BLANK : seg7(disp_t)) :
                       seg7(disp_u);
endmodule

// File: tb/tb_signed_display_scan.sv
// tb_signed_display_scan: table-driven, randomized and corner-case checks of signed_display_scan
module tb_signed_display_scan;
    localparam int DIV = 4;
    logic clk = 1'b0, rst = 1'b1, cargar = 1'b0;
    logic [7:0] valor = 8'd0;
    logic ocupado;
    logic [3:0] anodos;
    logic [6:0] segmentos;
    int checks = 0, errors = 0, since_rst = 0;
    bit mon = 1'b0;
    typedef struct {
        logic [7:0] v;
        logic [6:0] d3, d2, d1, d0;
    } vec_t;
    vec_t tbl [6];
    logic [6:0] dec [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    signed_display_scan #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .valor(valor), .cargar(cargar),
        .ocupado(ocupado), .anodos(anodos), .segmentos(segmentos)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask
    always @(posedge clk) since_rst <= rst ? 0 : since_rst + 1;
    always @(negedge clk) if (mon) chk("scan_anodos", {28'd0, anodos}, {28'd0, ~(4'b0001 << ((since_rst / DIV) % 4))});
    function automatic logic [27:0] model(input logic [7:0] v);
        int s, m, h, t, u;
        s = $signed(v);
        m = s < 0 ? -s : s;
        h = m / 100;
        t = (m / 10) % 10;
        u = m % 10;
        return {s < 0 ? 7'b0111111 : 7'b1111111, h == 0 ? 7'b1111111 : dec[h],
                (h == 0 && t == 0) ? 7'b1111111 : dec[t], dec[u]};
    endfunction
    task automatic read_disp(output logic [27:0] d);
        logic [6:0] g [4] = '{default: 7'h00};
        for (int k = 0; k < 4 * DIV; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) if (anodos == ~(4'b0001 << j)) g[j] = segmentos;
        end
        d = {g[3], g[2], g[1], g[0]};
    endtask
    task automatic wait_idle(output int n);
        n = 0;
        while (ocupado && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask
    task automatic load(input logic [7:0] v);
        int n;
        @(negedge clk);
        valor = v;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        wait_idle(n);
        chk("busy_cycles", n, 9);
    endtask
    initial begin
        logic [27:0] d;
        int n;
        tbl[0] = '{8'h80, 7'b0111111, 7'b1111001, 7'b0100100, 7'b0000000};
        tbl[1] = '{8'd7,  7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000};
        tbl[2] = '{8'hF6, 7'b0111111, 7'b1111111, 7'b1111001, 7'b1000000};
        tbl[3] = '{8'd127, 7'b1111111, 7'b1111001, 7'b0100100, 7'b1111000};
        tbl[4] = '{8'hFF, 7'b0111111, 7'b1111111, 7'b1111111, 7'b1111001};
        tbl[5] = '{8'd100, 7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000};
        repeat (2) @(negedge clk);
        chk("reset_ocupado", {31'd0, ocupado}, 0);
        chk("reset_anodos", {28'd0, anodos}, 32'b1110);
        chk("reset_seg", {25'd0, segmentos}, 32'b1000000);
        rst = 1'b0;
        mon = 1'b1;
        read_disp(d);
        chk("reset_disp", {4'd0, d}, {4'd0, 7'h7f, 7'h7f, 7'h7f, 7'b1000000});
        for (int i = 0; i < 6; i++) begin
            load(tbl[i].v);
            read_disp(d);
            chk($sformatf("table_%0h", tbl[i].v), {4'd0, d}, {4'd0, tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0});
        end
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            load(v);
            read_disp(d);
            chk($sformatf("rand_%0h", v), {4'd0, d}, {4'd0, model(v)});
        end
        @(negedge clk);
        valor = 8'd99;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        repeat (3) @(negedge clk);
        valor = 8'd1;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        wait_idle(n);
        chk("busy_ignore_timeout", {31'd0, ocupado}, 0);
        read_disp(d);
        chk("busy_ignore_disp", {4'd0, d}, {4'd0, model(8'd99)});
        @(negedge clk);
        valor = 8'hCE;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ocupado", {31'd0, ocupado}, 0);
        chk("abort_anodos", {28'd0, anodos}, 32'b1110);
        chk("abort_seg", {25'd0, segmentos}, 32'b1000000);
        rst = 1'b0;
        read_disp(d);
        chk("abort_disp", {4'd0, d}, {4'd0, 7'h7f, 7'h7f, 7'h7f, 7'b1000000});
        chk("abort_idle", {31'd0, ocupado}, 0);
        @(negedge clk);
        valor = 8'd42;
        cargar = 1'b1;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ocupado_%0d", k), {31'd0, ocupado}, k == 9 ? 0 : 1);
        end
        cargar = 1'b0;
        wait_idle(n);
        chk("b2b_end", {31'd0, ocupado}, 0);
        read_disp(d);
        chk("b2b_disp", {4'd0, d}, {4'd0, model(8'd42)});
        mon = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/signed_display_scan.md
# signed_display_scan

Sequential controller that takes a signed 8-bit two's-complement value, converts its magnitude to three BCD digits with a serial shift-add-3 (double-dabble) engine, and time-multiplexes a 4-digit common-anode seven-segment display. Digit 3 is the sign position: it is lit with the minus pattern for negative values and blanked otherwise. The block sits between the arithmetic datapath that produces results and the board display pins, and is the only driver of the anode and segment lines.

## Interface

- REFRESH_DIV, default 50000: clock cycles each digit stays enabled. Legal range is 1 or greater.
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- valor  input  8  signed two's-complement value to display.
- cargar  input  1  load strobe, sampled on clk while idle.
- ocupado  output  1  high while a conversion is in progress.
- anodos  output  4  digit enables, active-low, one-hot. Bit 3 is the leftmost digit (sign).
- segmentos  output  7  segment lines, active-low, order gfedcba.

## Operation

- **FSM states:** IDLE, CONV, COMMIT.
- **IDLE → CONV:** happens when cargar=1.
  - Latch signo = valor[7].
  - Latch mag = signo ? (~valor + 1) : valor, as unsigned 8 bits. -128 gives mag = 128.
  - Clear the BCD shift register (12 bits) and set the iteration counter to 0.
- **CONV:** 8 iterations, one per cycle.
  - Each iteration first adds 3 to any BCD nibble that is ≥5.
  - It then shifts {bcd, mag} left by 1.
  - After the 8th iteration the FSM moves to COMMIT.
- **COMMIT:** one cycle.
  - Copy the hundreds, tens and units nibbles and signo into the display registers.
  - Return to IDLE.
- **Busy handling:** cargar is ignored in CONV and COMMIT. There is no queuing. ocupado=1 exactly when state≠IDLE.
- **Display registers:** hold the last committed value. The display shows the previous value until COMMIT.
- **Scan counter:**
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- **Anodes:** anodos[i]=0 for the current index i, all other bits 1.
- **Segments per digit:**
  - Digit 3 (sign): 0111111 if signo, else 1111111.
  - Digit 2 (hundreds): 1111111 if the nibble is 0, else the decoded digit.
  - Digit 1 (tens): 1111111 if both hundreds and tens are 0, else the decoded digit.
  - Digit 0 (units): always decoded.
- **Digit decode (gfedcba, active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- **Output path:** anodos and segmentos are combinational decodes of the registered index and the display registers. They must not glitch from FSM activity.

## Timing

- **Reset values:**
  - State, iteration counter, refresh counter, digit index: IDLE, 0, 0, 0.
  - Display registers: value 0, positive.
  - Outputs: ocupado=0, anodos=1110, segmentos=1000000.
- **Conversion latency:**
  - cargar sampled at edge E0.
  - ocupado=1 from after E0 through E9.
  - CONV runs at E1..E8; COMMIT applies at E9.
  - New digits are visible and ocupado=0 after E9, i.e. 9 cycles busy.
- **Back-to-back loads:** cargar held high continuously reloads at the first edge where state=IDLE, which is the edge right after ocupado falls.
- **Reset mid-conversion:** rst aborts CONV/COMMIT. All registers return to their reset values at that edge, and the display shows units 0.
- **REFRESH_DIV=1:** the index advances every cycle.
- **Scan continuity:** scan timing is unaffected by cargar, ocupado or COMMIT.

## Test plan

- **Reset:** assert rst 2 cycles → ocupado=0, anodos=1110, segmentos=1000000, refresh counter 0.
- **Load -128:** valor=8'h80, cargar one cycle → ocupado high exactly 9 cycles. Then digit3=0111111, digit2=1111001, digit1=0100100, digit0=0000000.
- **Load 7 and -10:**
  - valor=8'd7 → digits 3/2/1 blank (1111111), digit0=1111000.
  - valor=8'hF6 → digit3=0111111, digit2 blank, digit1=1111001, digit0=1000000.
- **Busy and reset abort:**
  - Load 8'd99, then pulse cargar with 8'd1 on busy cycle 4 → display shows 99 (digit1 and digit0 =0010000); the second load is ignored.
  - Repeat with rst on busy cycle 5 → reset outputs, ocupado=0.
- **Scan timing:** with REFRESH_DIV=4 → anodos sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles, including across a load/COMMIT.
- **Boundary values:**
  - 8'd127 → sign blank, 1/2/7.
  - 8'hFF → minus sign, digits 2 and 1 blank, units 1111001.
  - 8'd100 → 1/0/0 with tens shown as 1000000 (not blanked).
